// File: rtl/quiz_scheduler.sv
// quiz_scheduler
//
// Paces a quiz game. A prescaler divides the system clock into game ticks.
// Every QUIZ_INTERVAL ticks spent in RUN, the block raises a quiz and waits
// up to ANSWER_WINDOW ticks for an answer. Passing MAX_QUIZ quizzes, or an
// external abort, ends the session in DONE. DONE holds until Reset.
//
// Parameters
//   TICK_DIV       clock cycles per game tick (>= 2)
//   QUIZ_INTERVAL  RUN ticks between quizzes (>= 1)
//   ANSWER_WINDOW  ticks allowed to answer a quiz (>= 1)
//   MAX_QUIZ       passed quizzes needed to finish (1..15)
//
// Ports
//   Clk             system clock, rising edge
//   Reset           asynchronous active-high reset
//   Start           one-cycle pulse that begins a session (IDLE only)
//   abort           level input, forces DONE with top priority
//   answer_valid    one-cycle pulse, an answer was submitted
//   answer_correct  answer result, qualified by answer_valid
//   q_IDLE..q_DONE  one-hot state flags
//   tick            one-cycle game-tick pulse
//   minutes         elapsed RUN ticks, saturating at 255
//   quiz_req        high throughout QUIZ
//   quiz_idx        quiz selector, cycles 1,2,3,1,... (0 after reset)
//   quiz_cnt        number of passed quizzes
//   miss            registered pulse after a wrong answer or a timeout
//   timeout         registered pulse after the answer window expires
module quiz_scheduler #(
    parameter int TICK_DIV      = 100000000,
    parameter int QUIZ_INTERVAL = 4,
    parameter int ANSWER_WINDOW = 2,
    parameter int MAX_QUIZ      = 9
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       abort,
    input  logic       answer_valid,
    input  logic       answer_correct,
    output logic       q_IDLE,
    output logic       q_RUN,
    output logic       q_QUIZ,
    output logic       q_DONE,
    output logic       tick,
    output logic [7:0] minutes,
    output logic       quiz_req,
    output logic [1:0] quiz_idx,
    output logic [3:0] quiz_cnt,
    output logic       miss,
    output logic       timeout
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int IW = $clog2(QUIZ_INTERVAL + 1);
    localparam int WW = $clog2(ANSWER_WINDOW + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] INT_LAST   = IW'(QUIZ_INTERVAL - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(ANSWER_WINDOW - 1);
    localparam logic [3:0]    CNT_LAST   = 4'(MAX_QUIZ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_QUIZ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [IW-1:0] int_cnt;
    logic [WW-1:0] win_cnt;

    logic          go_quiz;
    logic          ans_right;
    logic          ans_wrong;
    logic          expire;
    logic          changing;

    // The prescaler only moves in RUN and QUIZ, so outside those states it
    // sits at 0 and tick stays low without extra gating.
    assign tick     = (presc == PRESC_LAST);
    assign changing = (state_next != state);

    assign q_IDLE   = (state == S_IDLE);
    assign q_RUN    = (state == S_RUN);
    assign q_QUIZ   = (state == S_QUIZ);
    assign q_DONE   = (state == S_DONE);
    assign quiz_req = (state == S_QUIZ);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the one-cycle events that drive the datapath.
    // An answer in the same cycle as window expiry wins over the timeout.
    // abort overrides everything, including the events it would pre-empt.
    always_comb begin
        state_next = state;
        go_quiz    = 1'b0;
        ans_right  = 1'b0;
        ans_wrong  = 1'b0;
        expire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (tick && int_cnt == INT_LAST) begin
                    state_next = S_QUIZ;
                    go_quiz    = 1'b1;
                end
            end
            S_QUIZ: begin
                if (answer_valid) begin
                    if (answer_correct) begin
                        ans_right  = 1'b1;
                        state_next = (quiz_cnt == CNT_LAST) ? S_DONE : S_RUN;
                    end else begin
                        ans_wrong  = 1'b1;
                        state_next = S_RUN;
                    end
                end else if (tick && win_cnt == WIN_LAST) begin
                    expire     = 1'b1;
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_DONE;
            end
        endcase
        if (abort) begin
            state_next = S_DONE;
            go_quiz    = 1'b0;
            ans_right  = 1'b0;
            ans_wrong  = 1'b0;
            expire     = 1'b0;
        end
    end

    // Prescaler plus the interval and window counters. All three restart on
    // any state change so every RUN or QUIZ stay starts from a clean phase.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc   <= '0;
            int_cnt <= '0;
            win_cnt <= '0;
        end else begin
            if (changing || state == S_IDLE || state == S_DONE) begin
                presc <= '0;
            end else if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (changing) begin
                int_cnt <= '0;
            end else if (state == S_RUN && tick) begin
                int_cnt <= int_cnt + IW'(1);
            end

            if (changing) begin
                win_cnt <= '0;
            end else if (state == S_QUIZ && tick) begin
                win_cnt <= win_cnt + WW'(1);
            end
        end
    end

    // Session bookkeeping and the registered miss/timeout pulses. The tick
    // that launches a quiz still counts as a RUN minute; an abort on a tick
    // does not.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            minutes  <= '0;
            quiz_cnt <= '0;
            quiz_idx <= '0;
            miss     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            miss    <= ans_wrong | expire;
            timeout <= expire;

            if (state == S_IDLE && state_next == S_RUN) begin
                minutes <= '0;
            end else if (state == S_RUN && tick && !abort && minutes != 8'hFF) begin
                minutes <= minutes + 8'd1;
            end

            if (state == S_IDLE && state_next == S_RUN) begin
                quiz_cnt <= '0;
            end else if (ans_right) begin
                quiz_cnt <= quiz_cnt + 4'd1;
            end

            if (go_quiz) begin
                quiz_idx <= (quiz_idx == 2'd3) ? 2'd1 : quiz_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_quiz_scheduler.sv
// tb_quiz_scheduler
//
// Directed bench for quiz_scheduler with TICK_DIV=4, QUIZ_INTERVAL=3,
// ANSWER_WINDOW=2, MAX_QUIZ=2. A table of vectors walks one full session;
// hand-written sequences cover abort-on-tick, reset mid-quiz and the quiz
// selector rotation.
module tb_quiz_scheduler;

    localparam logic [3:0] E_IDLE = 4'b1000;
    localparam logic [3:0] E_RUN  = 4'b0100;
    localparam logic [3:0] E_QUIZ = 4'b0010;
    localparam logic [3:0] E_DONE = 4'b0001;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       abort = 1'b0;
    logic       answer_valid = 1'b0;
    logic       answer_correct = 1'b0;
    logic       q_IDLE, q_RUN, q_QUIZ, q_DONE;
    logic       tick;
    logic [7:0] minutes;
    logic       quiz_req;
    logic [1:0] quiz_idx;
    logic [3:0] quiz_cnt;
    logic       miss;
    logic       timeout;

    int num_checks = 0;
    int num_fail   = 0;

    // One vector: inputs held for the first edge only, then idle until
    // 'edges' rising edges have passed, then outputs are compared.
    typedef struct {
        logic       start;
        logic       abort;
        logic       av;
        logic       ac;
        int         edges;
        logic [3:0] q;
        logic       tick;
        logic [7:0] minutes;
        logic [1:0] idx;
        logic [3:0] cnt;
        logic       miss;
        logic       timeout;
    } vec_t;

    vec_t tbl[$];

    quiz_scheduler #(
        .TICK_DIV      (4),
        .QUIZ_INTERVAL (3),
        .ANSWER_WINDOW (2),
        .MAX_QUIZ      (2)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .abort          (abort),
        .answer_valid   (answer_valid),
        .answer_correct (answer_correct),
        .q_IDLE         (q_IDLE),
        .q_RUN          (q_RUN),
        .q_QUIZ         (q_QUIZ),
        .q_DONE         (q_DONE),
        .tick           (tick),
        .minutes        (minutes),
        .quiz_req       (quiz_req),
        .quiz_idx       (quiz_idx),
        .quiz_cnt       (quiz_cnt),
        .miss           (miss),
        .timeout        (timeout)
    );

    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic st, input logic ab, input logic av,
                                input logic ac, input int edges, input logic [3:0] q,
                                input logic tk, input logic [7:0] mins,
                                input logic [1:0] idx, input logic [3:0] cnt,
                                input logic ms, input logic to);
        vec_t v;
        v.start = st; v.abort = ab; v.av = av; v.ac = ac; v.edges = edges;
        v.q = q; v.tick = tk; v.minutes = mins; v.idx = idx; v.cnt = cnt;
        v.miss = ms; v.timeout = to;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v, input string tag);
        logic [3:0] flags;
        flags = {q_IDLE, q_RUN, q_QUIZ, q_DONE};
        checkOutput({tag, " state"}, 8'(flags), 8'(v.q));
        checkOutput({tag, " onehot"}, 8'($countones(flags)), 8'd1);
        checkOutput({tag, " tick"}, 8'(tick), 8'(v.tick));
        checkOutput({tag, " minutes"}, minutes, v.minutes);
        checkOutput({tag, " quiz_req"}, 8'(quiz_req), 8'(v.q[1]));
        checkOutput({tag, " quiz_idx"}, 8'(quiz_idx), 8'(v.idx));
        checkOutput({tag, " quiz_cnt"}, 8'(quiz_cnt), 8'(v.cnt));
        checkOutput({tag, " miss"}, 8'(miss), 8'(v.miss));
        checkOutput({tag, " timeout"}, 8'(timeout), 8'(v.timeout));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge Clk);
        Start          = v.start;
        abort          = v.abort;
        answer_valid   = v.av;
        answer_correct = v.ac;
        @(posedge Clk);
        #1;
        Start          = 1'b0;
        abort          = 1'b0;
        answer_valid   = 1'b0;
        answer_correct = 1'b0;
        repeat (v.edges - 1) begin
            @(posedge Clk);
            #1;
        end
        checkVector(v, tag);
    endtask

    task automatic applyReset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        checkVector(mk(0,0,0,0,0, E_IDLE, 0, 8'd0, 2'd0, 4'd0, 0, 0), "reset");
    endtask

    // Safety net so a stuck run still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] idx_seq [4];
        idx_seq[0] = 2'd1; idx_seq[1] = 2'd2; idx_seq[2] = 2'd3; idx_seq[3] = 2'd1;

        // Full session: quiz 1 passed, quiz 2 times out, answer outside QUIZ
        // ignored, quiz 3 wrong, quiz 4 wrong on the expiry tick, quiz 5
        // passed and reaches MAX_QUIZ, Start in DONE ignored.
        //               st ab av ac edg  state  tk  min  idx cnt ms to
        tbl.push_back(mk(1, 0, 0, 0,  1, E_RUN,  0, 8'd0,  2'd0, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  3, E_RUN,  1, 8'd0,  2'd0, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, E_RUN,  0, 8'd1,  2'd0, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  7, E_RUN,  1, 8'd2,  2'd0, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, E_QUIZ, 0, 8'd3,  2'd1, 4'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  1, E_RUN,  0, 8'd3,  2'd1, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 12, E_QUIZ, 0, 8'd6,  2'd2, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4, E_QUIZ, 0, 8'd6,  2'd2, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4, E_RUN,  0, 8'd6,  2'd2, 4'd1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0,  1, E_RUN,  0, 8'd6,  2'd2, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  1, E_RUN,  0, 8'd6,  2'd2, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 10, E_QUIZ, 0, 8'd9,  2'd3, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, E_RUN,  0, 8'd9,  2'd3, 4'd1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 12, E_QUIZ, 0, 8'd12, 2'd1, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  7, E_QUIZ, 1, 8'd12, 2'd1, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, E_RUN,  0, 8'd12, 2'd1, 4'd1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 12, E_QUIZ, 0, 8'd15, 2'd2, 4'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1,  1, E_DONE, 0, 8'd15, 2'd2, 4'd2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  5, E_DONE, 0, 8'd15, 2'd2, 4'd2, 0, 0));

        Reset = 1'b1;
        #12;
        applyReset();
        foreach (tbl[i]) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Abort on a tick cycle: DONE without the minute; Start and an
        // answer afterwards change nothing.
        applyReset();
        applyStimulus(mk(1,0,0,0, 1, E_RUN,  0, 8'd0, 2'd0, 4'd0, 0, 0), "abrt start");
        applyStimulus(mk(0,0,0,0, 3, E_RUN,  1, 8'd0, 2'd0, 4'd0, 0, 0), "abrt pre");
        applyStimulus(mk(0,1,0,0, 1, E_DONE, 0, 8'd0, 2'd0, 4'd0, 0, 0), "abrt tick");
        applyStimulus(mk(1,0,1,1, 6, E_DONE, 0, 8'd0, 2'd0, 4'd0, 0, 0), "abrt later");

        // Reset in the middle of a quiz, asserted between clock edges.
        applyReset();
        applyStimulus(mk(1,0,0,0, 1,  E_RUN,  0, 8'd0, 2'd0, 4'd0, 0, 0), "rq start");
        applyStimulus(mk(0,0,0,0, 12, E_QUIZ, 0, 8'd3, 2'd1, 4'd0, 0, 0), "rq quiz");
        applyStimulus(mk(0,0,0,0, 7,  E_QUIZ, 1, 8'd3, 2'd1, 4'd0, 0, 0), "rq late");
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checkVector(mk(0,0,0,0,0, E_IDLE, 0, 8'd0, 2'd0, 4'd0, 0, 0), "rq async");
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk);
            #1;
            checkOutput($sformatf("rq miss c%0d", c), 8'(miss), 8'd0);
            checkOutput($sformatf("rq timeout c%0d", c), 8'(timeout), 8'd0);
        end

        // Selector rotation across four quizzes after the reset above.
        applyStimulus(mk(1,0,0,0, 1, E_RUN, 0, 8'd0, 2'd0, 4'd0, 0, 0), "rot start");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mk(0,0,0,0, 12, E_QUIZ, 0, 8'(3 * (k + 1)), idx_seq[k],
                             4'd0, 0, 0), $sformatf("rot quiz%0d", k));
            applyStimulus(mk(0,0,1,0, 1, E_RUN, 0, 8'(3 * (k + 1)), idx_seq[k],
                             4'd0, 1, 0), $sformatf("rot wrong%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 num_checks, num_fail);
        $finish;
    end

endmodule
